prng_sched: RTL and testbench

PRNG_SCHED -- requirements
Module: prng_sched

---
 rtl/prng_pkg.sv | 18 +
 rtl/lfsr32_step.sv | 15 +
 rtl/prng_sched.sv | 126 ++++++++++++
 tb/tb_prng_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared definitions for the round-robin PRNG scheduler.
//   WIDTH        : LFSR / random word width
//   POLY_DEFAULT : Galois taps for x^32+x^7+x^5+x^3+x^2+x+1
//   state_e      : scheduler FSM states
package prng_pkg;

  localparam int unsigned WIDTH = 32;

  localparam logic [WIDTH-1:0] POLY_DEFAULT = 32'h0000_00AF;

  typedef enum logic [1:0] {
    StIdle, // unseeded
    StSeed, // seed just loaded
    StWarm, // stepping the LFSR before first grant
    StRun   // serving requests
  } state_e;

endpackage

// File: rtl/lfsr32_step.sv
// Combinational next-state function of a 32-bit Galois LFSR.
//   cur : current LFSR state
//   nxt : state after one shift
module lfsr32_step
  import prng_pkg::*;
#(
  parameter logic [WIDTH-1:0] POLY = POLY_DEFAULT
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  assign nxt = {cur[WIDTH-2:0], 1'b0} ^ (cur[WIDTH-1] ? POLY : '0);

endmodule

// File: rtl/prng_sched.sv
// Hands out consecutive LFSR words to N_REQ requesters with round-robin arbitration.
// After a seed load the LFSR is stepped WARM_CYC times before any grant.
//   clk, rst_n          : clock, synchronous active-low reset
//   seed_valid/seed     : seed offer (always accepted, highest priority)
//   seed_ready          : constant 1
//   req                 : per-requester level request
//   gnt                 : registered one-hot grant
//   rnd_valid/rnd_data  : random word for the granted requester (data is 0 when not valid)
//   busy                : high while seeding / warming up
module prng_sched
  import prng_pkg::*;
#(
  parameter int unsigned      N_REQ    = 4,
  parameter int unsigned      WARM_CYC = 32,
  parameter logic [WIDTH-1:0] POLY     = POLY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed,
  output logic             seed_ready,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             rnd_valid,
  output logic [WIDTH-1:0] rnd_data,
  output logic             busy
);

  localparam int unsigned PtrW     = $clog2(N_REQ);
  localparam logic [7:0]  WarmLast = 8'(WARM_CYC - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d, s_next;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [7:0]       warm_q, warm_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0] rnd_q, rnd_d;

  // Arbiter search signals
  logic             found;
  logic [PtrW-1:0]  gnt_idx;
  logic [PtrW:0]    cand;
  logic [PtrW:0]    ptr_inc;

  lfsr32_step #(
    .POLY(POLY)
  ) u_step (
    .cur(s_q),
    .nxt(s_next)
  );

  // Round-robin: first asserted req at or after ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      cand = {1'b0, ptr_q} + (PtrW+1)'(i);
      if (cand >= (PtrW+1)'(N_REQ)) cand = cand - (PtrW+1)'(N_REQ);
      if (!found && req[cand[PtrW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[PtrW-1:0];
      end
    end
    ptr_inc = {1'b0, gnt_idx} + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    ptr_d   = ptr_q;
    warm_d  = warm_q;
    gnt_d   = '0;
    rnd_d   = '0;
    if (seed_valid) begin
      // A zero seed would lock the LFSR at zero.
      s_d     = (seed == '0) ? WIDTH'(1) : seed;
      warm_d  = '0;
      state_d = StSeed;
    end else begin
      unique case (state_q)
        StIdle: ;
        StSeed: state_d = StWarm;
        StWarm: begin
          s_d    = s_next;
          warm_d = warm_q + 8'd1;
          if (warm_q == WarmLast) state_d = StRun;
        end
        StRun: begin
          if (found) begin
            gnt_d[gnt_idx] = 1'b1;
            rnd_d          = s_q;
            s_d            = s_next;
            ptr_d          = (ptr_inc == (PtrW+1)'(N_REQ)) ? '0 : ptr_inc[PtrW-1:0];
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      s_q     <= '0;
      ptr_q   <= '0;
      warm_q  <= '0;
      gnt_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      ptr_q   <= ptr_d;
      warm_q  <= warm_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
    end
  end

  assign seed_ready = 1'b1;
  assign gnt        = gnt_q;
  assign rnd_valid  = |gnt_q;
  assign rnd_data   = rnd_q;
  assign busy       = (state_q == StSeed) || (state_q == StWarm);

endmodule

// File: tb/tb_prng_sched.sv
// Scoreboard bench for prng_sched: a reference model predicts grants into a queue,
// a negedge monitor pops and compares whenever the DUT shows a grant.
module tb_prng_sched;

  localparam int          N  = 4;
  localparam int          WC = 32;
  localparam logic [31:0] P  = 32'h0000_00AF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          seed_valid = 1'b0;
  logic [31:0]   seed = '0;
  logic          seed_ready;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gnt;
  logic          rnd_valid;
  logic [31:0]   rnd_data;
  logic          busy;

  always #5 clk = ~clk;

  prng_sched #(
    .N_REQ   (N),
    .WARM_CYC(WC),
    .POLY    (P)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_valid(seed_valid),
    .seed      (seed),
    .seed_ready(seed_ready),
    .req       (req),
    .gnt       (gnt),
    .rnd_valid (rnd_valid),
    .rnd_data  (rnd_data),
    .busy      (busy)
  );

  typedef struct {
    int unsigned  cyc;
    logic [N-1:0] g;
    logic [31:0]  d;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Reference model state
  bit           m_seeded = 0;
  logic [31:0]  m_s = '0;
  int           m_ptr = 0;
  int           m_pre = 0;   // seed-load cycles left
  int           m_warm = 0;  // warm-up steps left
  logic [N-1:0] m_g = '0;    // grant predicted for the coming cycle
  bit           exp_busy = 0;
  int unsigned  drv_edges = 0;
  int unsigned  n_pos = 0;

  always @(posedge clk) n_pos <= n_pos + 1;

  function automatic logic [31:0] step(input logic [31:0] s);
    return (s << 1) ^ (s[31] ? P : 32'h0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model();
    m_g = '0;
    if (!rst_n) begin
      m_seeded = 0; m_s = '0; m_ptr = 0; m_pre = 0; m_warm = 0;
    end else if (seed_valid) begin
      m_seeded = 1; m_s = (seed == 0) ? 32'h1 : seed; m_pre = 1; m_warm = WC;
    end else if (!m_seeded) begin
    end else if (m_pre > 0) begin
      m_pre--;
    end else if (m_warm > 0) begin
      m_s = step(m_s);
      m_warm--;
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (req[i]) begin
          m_g[i] = 1'b1;
          q.push_back('{cyc: drv_edges, g: m_g, d: m_s});
          m_s = step(m_s);
          m_ptr = (i + 1) % N;
          break;
        end
      end
    end
    exp_busy = m_seeded && (m_pre > 0 || m_warm > 0);
  endtask

  // One clock: model consumes the inputs present at the edge; inputs change 1ns later.
  task automatic tick();
    @(posedge clk);
    drv_edges++;
    model();
    #1;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (n_pos >= 1) begin
      check("busy", 64'(busy), 64'(exp_busy));
      check("seed_ready", 64'(seed_ready), 64'd1);
      check("valid_eq_or_gnt", 64'(rnd_valid), 64'(gnt != '0));
      if (!rnd_valid) check("data_zero_idle", 64'(rnd_data), 64'd0);
      if (q.size() > 0 && q[0].cyc == n_pos) begin
        exp_t e;
        e = q.pop_front();
        check("grant_valid", 64'(rnd_valid), 64'd1);
        check("grant_onehot", 64'(gnt), 64'(e.g));
        check("grant_data", 64'(rnd_data), 64'(e.d));
      end else if (rnd_valid) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got gnt=%0h data=%0h expected no grant (t=%0t)",
                 gnt, rnd_data, $time);
      end
    end
  end

  // Seed with req=0001 held; check warm-up length and first two words.
  task automatic run_seed_check(input logic [31:0] sv);
    int bcnt, ngr;
    logic [31:0] d[2];
    logic [N-1:0] g[2];
    bcnt = 0; ngr = 0;
    d[0] = '0; d[1] = '0; g[0] = '0; g[1] = '0;
    req = 4'b0001; seed = sv; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    if (busy) bcnt++;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (busy) bcnt++;
      if (rnd_valid && ngr < 2) begin
        d[ngr] = rnd_data; g[ngr] = gnt; ngr++;
      end
    end
    check("busy_cycles", 64'(bcnt), 64'd33);
    check("first_gnt", 64'(g[0]), 64'h1);
    check("first_data", 64'(d[0]), 64'h0000_00AF);
    check("second_gnt", 64'(g[1]), 64'h1);
    check("second_data", 64'(d[1]), 64'h0000_015E);
    req = '0;
    tick();
  endtask

  initial begin
    int ng;
    logic [N-1:0] gs[8];
    logic [31:0]  ds[8];
    int distinct;
    bit seen;

    // Reset
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_gnt", 64'(gnt), 64'd0);
    check("reset_data", 64'(rnd_data), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    req = 4'b1111;
    repeat (3) tick();  // unseeded: no grants
    req = '0;

    run_seed_check(32'h1);
    run_seed_check(32'h0);

    // Round-robin over all four from ptr=0
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    seed = 32'h1234_5678; seed_valid = 1'b1; tick(); seed_valid = 1'b0;
    repeat (WC + 2) tick();
    req = 4'b1111;
    ng = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 7) req = '0;
      if (rnd_valid && ng < 8) begin gs[ng] = gnt; ds[ng] = rnd_data; ng++; end
    end
    tick();
    if (rnd_valid && ng < 8) begin gs[ng] = gnt; ds[ng] = rnd_data; ng++; end
    check("rr_count", 64'(ng), 64'd8);
    for (int k = 0; k < 8 && k < ng; k++) check("rr_order", 64'(gs[k]), 64'(4'b0001 << (k % 4)));
    distinct = 1;
    for (int a = 0; a < ng; a++)
      for (int b = a + 1; b < ng; b++)
        if (ds[a] == ds[b]) distinct = 0;
    check("rr_distinct", 64'(distinct), 64'd1);

    // Idle gap then single request: model checks the word continues the sequence
    repeat (10) tick();
    req = 4'b0100; tick(); req = '0; tick();

    // Reseed in RUN with a pending request
    req = 4'b0011; seed = 32'h1; seed_valid = 1'b1; tick(); seed_valid = 1'b0;
    check("reseed_no_grant", 64'(rnd_valid), 64'd0);
    seen = 0;
    for (int c = 0; c < WC + 4; c++) begin
      tick();
      if (rnd_valid && !seen) begin
        seen = 1;
        check("reseed_first_data", 64'(rnd_data), 64'h0000_00AF);
        req = req & ~gnt;
      end
    end
    check("reseed_granted", 64'(seen), 64'd1);
    req = '0; tick();

    // Reset mid-warm discards the seed
    seed = 32'hCAFE_F00D; seed_valid = 1'b1; tick(); seed_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 4'b1111;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (rnd_valid) seen = 1;
    end
    check("no_grant_after_reset", 64'(seen), 64'd0);
    req = '0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] newreq;
      rst_n = ($urandom_range(0, 299) != 0);
      seed_valid = ($urandom_range(0, 59) == 0);
      seed = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      newreq = N'($urandom) & N'($urandom);
      tick();
      req = (req & ~m_g) | newreq;
    end
    rst_n = 1'b1; seed_valid = 1'b0; req = '0;
    repeat (3) tick();
    @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
